// File: rtl/ranger_pkg.sv
// Shared types and sizing helpers for the ultrasonic ranging front end.
// Widths are derived from the instantiating module's parameters through these helpers.
package ranger_pkg;

  localparam int DIST_W = 9;

  typedef logic [DIST_W-1:0] dist_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_e;

  // Clock cycles per microsecond.
  function automatic int us_div_f(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Bits needed to hold 0..max_val.
  function automatic int cnt_w_f(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ranger_us_tick.sv
// Microsecond prescaler: counts 0..US_DIV-1 and flags the terminal count.
// A synchronous clear restarts the count so each FSM state starts on a fresh microsecond.
module ranger_us_tick
  import ranger_pkg::*;
#(
  parameter int US_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic us_tick
);

  localparam int            CW   = cnt_w_f(US_DIV - 1);
  localparam logic [CW-1:0] TERM = CW'(US_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == TERM)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign us_tick = (cnt_q == TERM);

endmodule

// File: rtl/ultrasonic_ranger.sv
// Trigger generation, echo timing and divider-free centimetre conversion
// for an ultrasonic range sensor; publishes a distance with valid/timeout strobes.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60_000,
  parameter int TIMEOUT_US = 25_000,
  parameter int CM_US      = 58,
  parameter int MAX_CM     = 400
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  echo,
  output logic  trig,
  output dist_t distance_cm,
  output logic  valid,
  output logic  timeout,
  output logic  no_target
);

  localparam int US_DIV = us_div_f(CLK_HZ);
  localparam int PW     = cnt_w_f(PERIOD_US);
  localparam int WW     = cnt_w_f(TIMEOUT_US);
  localparam int SW     = cnt_w_f(CM_US - 1);

  localparam logic [PW-1:0]     PERIOD_LIM = PW'(PERIOD_US);
  localparam logic [PW-1:0]     TRIG_LAST  = PW'(TRIG_US - 1);
  localparam logic [WW-1:0]     TO_LIM     = WW'(TIMEOUT_US);
  localparam logic [SW-1:0]     SUB_LAST   = SW'(CM_US - 1);
  localparam logic [DIST_W-1:0] CM_MAX     = DIST_W'(MAX_CM);

  state_e          state_q, state_d;
  logic            sync1_q, echo_s_q;
  logic [PW-1:0]   period_q, period_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [SW-1:0]   sub_q, sub_d;
  dist_t           cm_q, cm_d;
  logic            to_q, to_d;
  logic            trig_q, trig_d;
  dist_t           dist_q, dist_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic            nt_q, nt_d;
  logic            us_tick;
  logic            state_chg;

  assign state_chg = (state_d != state_q);

  ranger_us_tick #(.US_DIV(US_DIV)) u_us_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_chg),
    .us_tick(us_tick)
  );

  // Next-state logic; an echo fall takes priority over an expiring wait.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if ((period_q >= PERIOD_LIM) && !echo_s_q) begin
          state_d = TRIG;
        end else begin
          state_d = IDLE;
        end
      end
      TRIG: begin
        if (us_tick && (period_q == TRIG_LAST)) begin
          state_d = WAIT_ECHO;
        end else begin
          state_d = TRIG;
        end
      end
      WAIT_ECHO: begin
        if (echo_s_q) begin
          state_d = MEASURE;
        end else if (wait_q >= TO_LIM) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          state_d = WAIT_ECHO;
        end
      end
      MEASURE: begin
        if (!echo_s_q) begin
          state_d = DONE;
          to_d    = 1'b0;
        end else if (wait_q >= TO_LIM) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          state_d = MEASURE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Microsecond counters; sub/cm convert echo width to cm by repeated CM_US counts.
  always_comb begin
    period_d = period_q;
    wait_d   = wait_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    if ((state_q != TRIG) && (state_d == TRIG)) begin
      period_d = '0;
    end else if (us_tick && (period_q != PERIOD_LIM)) begin
      period_d = period_q + PW'(1);
    end else begin
      period_d = period_q;
    end
    if (state_q == TRIG) begin
      wait_d = '0;
    end else if (us_tick && ((state_q == WAIT_ECHO) || (state_q == MEASURE)) && (wait_q != TO_LIM)) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end
    if ((state_q != MEASURE) && (state_d == MEASURE)) begin
      sub_d = '0;
      cm_d  = '0;
    end else if ((state_q == MEASURE) && us_tick) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        cm_d  = (cm_q >= CM_MAX) ? CM_MAX : (cm_q + DIST_W'(1));
      end else begin
        sub_d = sub_q + SW'(1);
        cm_d  = cm_q;
      end
    end else begin
      sub_d = sub_q;
      cm_d  = cm_q;
    end
  end

  // Output next values, published one cycle after DONE.
  always_comb begin
    trig_d    = (state_d == TRIG);
    valid_d   = (state_q == DONE) && !to_q;
    timeout_d = (state_q == DONE) && to_q;
    if (valid_d) begin
      dist_d = cm_q;
    end else begin
      dist_d = dist_q;
    end
    if (state_q == DONE) begin
      nt_d = to_q;
    end else begin
      nt_d = nt_q;
    end
  end

  // State, synchroniser, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      echo_s_q  <= 1'b0;
      period_q  <= PERIOD_LIM;
      wait_q    <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      to_q      <= 1'b0;
      trig_q    <= 1'b0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      nt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= echo;
      echo_s_q  <= sync1_q;
      period_q  <= period_d;
      wait_q    <= wait_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      to_q      <= to_d;
      trig_q    <= trig_d;
      dist_q    <= dist_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      nt_q      <= nt_d;
    end
  end

  assign trig        = trig_q;
  assign distance_cm = dist_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign no_target   = nt_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed and randomized bench for ultrasonic_ranger with a scaled-down clock and
// timing parameters; expected distances come from the width/US_DIV/CM_US arithmetic.
module tb_ultrasonic_ranger;

  localparam int CLK_HZ     = 4_000_000;
  localparam int US_DIV     = 4;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_US  = 400;
  localparam int TIMEOUT_US = 2000;
  localparam int CM_US      = 58;
  localparam int MAX_CM     = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       echo;
  logic       trig;
  logic [8:0] distance_cm;
  logic       valid;
  logic       timeout;
  logic       no_target;

  int     checks = 0;
  int     errors = 0;
  longint t_now = 0;
  longint last_rise = 0;
  bit     have_rise = 1'b0;
  int     exp_dist = 0;
  bit     exp_nt = 1'b0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .CLK_HZ    (CLK_HZ),
    .TRIG_US   (TRIG_US),
    .PERIOD_US (PERIOD_US),
    .TIMEOUT_US(TIMEOUT_US),
    .CM_US     (CM_US),
    .MAX_CM    (MAX_CM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .echo       (echo),
    .trig       (trig),
    .distance_cm(distance_cm),
    .valid      (valid),
    .timeout    (timeout),
    .no_target  (no_target)
  );

  task automatic step();
    @(posedge clk);
    #1;
    t_now++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: whole microseconds of echo, whole centimetres, then saturate.
  function automatic int model_cm(input int wid_cycles);
    int c;
    c = (wid_cycles / US_DIV) / CM_US;
    return (c > MAX_CM) ? MAX_CM : c;
  endfunction

  task automatic trig_cycle();
    int t;
    int hw;
    int stray;
    t = 0;
    stray = 0;
    while (trig !== 1'b1 && t < 4 * PERIOD_US * US_DIV) begin
      if (valid === 1'b1 || timeout === 1'b1) stray++;
      step();
      t++;
    end
    chk("trig_rise", trig, 1);
    chk("stray_strobe", stray, 0);
    if (have_rise) chk("trig_spacing", (t_now - last_rise) >= longint'(PERIOD_US * US_DIV), 1);
    last_rise = t_now;
    have_rise = 1'b1;
    hw = 0;
    while (trig === 1'b1 && hw < 4 * TRIG_US * US_DIV) begin
      hw++;
      step();
    end
    chk("trig_width", hw, TRIG_US * US_DIV);
  endtask

  // One trigger, then echo high from dly_us after trig falls for wid cycles (wid=0: no echo).
  task automatic measure(input int dly_us, input int wid);
    int t_evt, nv, nto, both, e0, e1;
    bit exp_to;
    trig_cycle();
    e0 = dly_us * US_DIV;
    e1 = e0 + wid;
    exp_to = (wid == 0) || (e1 > TIMEOUT_US * US_DIV);
    nv = 0; nto = 0; both = 0; t_evt = -1;
    for (int t = 0; t < (TIMEOUT_US + 300) * US_DIV; t++) begin
      echo = (t >= e0 && t < e1);
      step();
      if (valid === 1'b1) nv++;
      if (timeout === 1'b1) nto++;
      if (valid === 1'b1 && timeout === 1'b1) both++;
      if ((valid === 1'b1 || timeout === 1'b1) && t_evt < 0) t_evt = t + 1;
      else if (t_evt >= 0 && t >= e1) break;
    end
    echo = 1'b0;
    chk("strobe_seen", t_evt >= 0, 1);
    chk("strobe_overlap", both, 0);
    if (exp_to) begin
      chk("timeout_pulses", nto, 1);
      chk("valid_pulses_on_to", nv, 0);
      chk("timeout_time", (t_evt >= TIMEOUT_US * US_DIV + 2) && (t_evt <= TIMEOUT_US * US_DIV + US_DIV + 4), 1);
      exp_nt = 1'b1;
    end else begin
      chk("valid_pulses", nv, 1);
      chk("timeout_pulses_on_valid", nto, 0);
      chk("valid_latency", t_evt, e1 + 4);
      exp_dist = model_cm(wid);
      exp_nt = 1'b0;
    end
    chk("distance_cm", distance_cm, exp_dist);
    chk("no_target", no_target, exp_nt);
  endtask

  initial begin
    int rises;
    rst = 1'b1;
    echo = 1'b0;

    // Reset: every output low while rst is held.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_trig", trig, 0);
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_distance", distance_cm, 0);
      chk("rst_no_target", no_target, 0);
    end
    rst = 1'b0;
    step();
    chk("trig_after_reset", trig, 1);

    // Rounding boundaries around 10 cm, then no echo, then recovery.
    measure(30, 2322);
    measure(30, 2319);
    measure(0, 0);
    measure(30, 4640);

    // Saturation and an echo outlasting the timeout.
    measure(20, 6400);
    measure(20, 8800);

    // Exact multiple of one centimetre and one cycle short of it.
    measure(10, 3 * CM_US * US_DIV);
    measure(10, 3 * CM_US * US_DIV - 1);

    // Reset in the middle of MEASURE discards the measurement.
    trig_cycle();
    repeat (20 * US_DIV) step();
    echo = 1'b1;
    repeat (300 * US_DIV) step();
    rst = 1'b1;
    echo = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_trig", trig, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_timeout", timeout, 0);
    chk("midrst_distance", distance_cm, 0);
    chk("midrst_no_target", no_target, 0);
    exp_dist = 0;
    exp_nt = 1'b0;
    have_rise = 1'b0;
    measure(15, 1200);

    // Echo stuck high across IDLE blocks the trigger until it falls.
    measure(20, 400);
    echo = 1'b1;
    rises = 0;
    for (int i = 0; i < 500 * US_DIV; i++) begin
      step();
      if (trig === 1'b1) rises++;
    end
    chk("stuck_echo_no_trig", rises, 0);
    echo = 1'b0;
    step();
    step();
    chk("release_trig_early", trig, 0);
    step();
    chk("release_trig", trig, 1);
    measure(10, 1000);

    // Randomized widths well inside the timeout window.
    for (int n = 0; n < 6; n++) begin
      int d;
      int w;
      d = int'($urandom_range(5, 100));
      w = int'($urandom_range(4, 1000 * US_DIV));
      measure(d, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
